// File: rtl/vga_sync_if.sv
// Raster timing bundle driven by vga_sync_gen and consumed by the pixel
// generator and other display logic.
interface vga_sync_if;
  logic       p_tick;
  logic [9:0] x;
  logic [9:0] y;
  logic       video_on;
  logic       hsync;
  logic       vsync;
  logic       frame_tick;

  modport master (
    output p_tick, x, y, video_on, hsync, vsync, frame_tick
  );

  modport slave (
    input p_tick, x, y, video_on, hsync, vsync, frame_tick
  );
endinterface

// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel-rate divider, h/v counters, registered
// sync pulses and combinational video_on / frame_tick.
module vga_sync_gen #(
  parameter int DIV       = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  vga_sync_if.master o_vga
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic [9:0]       r_h_cnt;
  logic [9:0]       r_v_cnt;
  logic             r_hsync;
  logic             r_vsync;

  logic       w_p_tick;
  logic       w_h_last;
  logic       w_v_last;
  logic [9:0] w_h_next;
  logic [9:0] w_v_next;
  logic       w_hsync_next;
  logic       w_vsync_next;

  // With DIV=1 the divider sits at 0 == DIV-1, so the tick is permanently high.
  assign w_p_tick = (r_div_cnt == DIV_LAST);
  assign w_h_last = (r_h_cnt == H_LAST);
  assign w_v_last = (r_v_cnt == V_LAST);

  always_comb begin
    w_h_next = r_h_cnt;
    w_v_next = r_v_cnt;
    if (w_p_tick) begin
      if (w_h_last) begin
        w_h_next = 10'd0;
        w_v_next = w_v_last ? 10'd0 : r_v_cnt + 10'd1;
      end else begin
        w_h_next = r_h_cnt + 10'd1;
      end
    end
  end

  // Sync levels come from the next counter values so they switch with x/y.
  assign w_hsync_next = ((w_h_next >= HS_START) && (w_h_next <= HS_END)) ? SYNC_POL : ~SYNC_POL;
  assign w_vsync_next = ((w_v_next >= VS_START) && (w_v_next <= VS_END)) ? SYNC_POL : ~SYNC_POL;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_cnt <= '0;
      r_h_cnt   <= 10'd0;
      r_v_cnt   <= 10'd0;
      r_hsync   <= ~SYNC_POL;
      r_vsync   <= ~SYNC_POL;
    end else begin
      r_div_cnt <= w_p_tick ? '0 : r_div_cnt + DIV_W'(1);
      r_h_cnt   <= w_h_next;
      r_v_cnt   <= w_v_next;
      r_hsync   <= w_hsync_next;
      r_vsync   <= w_vsync_next;
    end
  end

  assign o_vga.p_tick     = w_p_tick;
  assign o_vga.x          = r_h_cnt;
  assign o_vga.y          = r_v_cnt;
  assign o_vga.video_on   = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
  assign o_vga.hsync      = r_hsync;
  assign o_vga.vsync      = r_vsync;
  assign o_vga.frame_tick = w_p_tick && w_h_last && w_v_last;

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Raster timing generator: produces the pixel coordinates x/y, video_on, the pixel-rate tick and the monitor sync pulses. The pixel generator and other display logic consume these.
- Default timing is 640x480 at 60 Hz: 800 clocks per line, 525 lines per frame, 25 MHz pixel rate derived from a 100 MHz system clock.
- Coordinates advance only on pixel ticks; everything runs on one clock domain.

Parameters:
- DIV, 4, system clocks per pixel (>=1).
- H_DISPLAY, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch (pixels).
- H_SYNC, 96, hsync width (pixels).
- H_BACK, 48, horizontal back porch (pixels).
- V_DISPLAY, 480, visible lines.
- V_FRONT, 10, vertical front porch (lines).
- V_SYNC, 2, vsync width (lines).
- V_BACK, 33, vertical back porch (lines).
- SYNC_POL, 0, active level of hsync/vsync (0 = active low).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- p_tick  out  1  one-clk pulse at pixel rate.
- x  out  10  horizontal counter value, 0..H_TOTAL-1.
- y  out  10  vertical counter value, 0..V_TOTAL-1.
- video_on  out  1  high when the current (x,y) is in the visible area.
- hsync  out  1  horizontal sync.
- vsync  out  1  vertical sync.
- frame_tick  out  1  one-clk pulse on the last pixel tick of each frame.

Behaviour:
- Derived constants: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525). Both must be <=1024.
- Divider:
  - div_cnt counts 0..DIV-1 every clk and wraps to 0.
  - p_tick = (div_cnt == DIV-1), combinational from the register.
  - DIV=1: p_tick is constantly 1.
- Horizontal counter (h_cnt): on a clk edge with p_tick=1, increments; at H_TOTAL-1 it wraps to 0.
- Vertical counter (v_cnt): increments on the same edge where h_cnt wraps; at V_TOTAL-1 it wraps to 0.
- x = h_cnt and y = v_cnt, both direct register outputs.
- x/y stay constant for DIV clks per pixel.
- video_on = (h_cnt < H_DISPLAY) && (v_cnt < V_DISPLAY), combinational from the counters.
- hsync and vsync are registered, with the next state computed from the next counter values, so they change on the same clk edge as x/y.
  - hsync is at SYNC_POL while x is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1], i.e. 656..751; otherwise at ~SYNC_POL.
  - vsync is at SYNC_POL while y is in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1], i.e. 490..491; otherwise at ~SYNC_POL.
- frame_tick = p_tick && h_cnt==H_TOTAL-1 && v_cnt==V_TOTAL-1, combinational. The next edge sets x=0, y=0.
- Reset (asynchronous, any time, including mid-line or mid-frame):
  - div_cnt=0, h_cnt=0, v_cnt=0.
  - hsync and vsync = ~SYNC_POL (inactive).
  - Consequently p_tick=0 (for DIV>1), video_on=1, frame_tick=0.
- After reset release: the first p_tick occurs on the DIV-th clk (its rising edge is the edge where div_cnt reaches DIV-1). The first x increment happens on the following edge.
- Counter arithmetic is 10-bit unsigned. Counters never exceed TOTAL-1; there is no saturation path.
- No inputs other than clk/reset; no handshake. Downstream logic samples x/y/video_on on p_tick or on any clk.

Test Plan:
- Reset and tick cadence: assert reset mid-count, release, defaults. Outputs immediately x=0, y=0, hsync=vsync=1, video_on=1. p_tick pulses exactly every 4 clks, first pulse at the 4th clk after release.
- Line timing, defaults:
  - x sequences 0..799 then wraps to 0, y increments by 1 at the wrap.
  - hsync=0 exactly for x=656..751 (96 pixels), 1 elsewhere.
  - video_on falls at x=640 and rises at x=0.
- Frame timing:
  - y runs 0..524 then wraps; vsync=0 exactly for y=490..491 (1600 pixel ticks).
  - video_on=0 for all of y>=480.
  - frame_tick pulses once per 420000 pixel ticks, at x=799, y=524.
- Mid-frame reset: reset asserted at x=700, y=490 (hsync and vsync both active). Both go to 1 asynchronously before the next clk edge; counters go to 0. Timing restarts cleanly.
- DIV=1, SYNC_POL=1:
  - p_tick is constantly 1; x advances every clk.
  - hsync=1 only for x=656..751; vsync=1 only for y=490..491.
  - frame length is 420000 clks.
